rename_stage: RTL and testbench
===============================

Name: rename_stage

Overview:
- In-order rename/dispatch stage directly upstream of the 256-entry reorder buffer.
- Accepts one decoded instruction per cycle and allocates its ROB slot through the ROB alloc handshake.
- Resolves each source operand to either an architectural value (ready) or an in-flight ROB tag, and records dst -> slot in a register alias table (RAT).
- Owns the architectural register file (ARF), which is written by the commit path. Emits a registered packet to issue.

Parameters:
XLEN, 64, data/PC width
NUM_ARF, 32, architectural registers (r0 hardwired zero)
ARF_BITS, 5, log2(NUM_ARF)
TAG_BITS, 8, ROB slot index width (256 slots)

Ports:
clock  in  1  clock
_reset  in  1  asynchronous, active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_pc  in  XLEN  instruction PC
in_src1, in_src2  in  ARF_BITS  source arch regs
in_dst  in  ARF_BITS  dest arch reg (0 = no destination)
rob_next_free  in  TAG_BITS  slot ROB will allocate next
rob_is_free  in  1  ROB not full
rob_do_alloc  out  1  allocate strobe
rob_alloc_arf  out  ARF_BITS  = in_dst
rob_alloc_pc  out  XLEN  = in_pc
commit_valid  in  1  one instruction retires this cycle
commit_slot  in  TAG_BITS  retiring ROB slot
commit_arf  in  ARF_BITS  retiring dest
commit_result  in  XLEN  retiring value
flush  in  1  discard all in-flight speculative state
out_valid  out  1  packet to issue valid
out_ready  in  1  issue accepts packet
out_pc  out  XLEN
out_slot  out  TAG_BITS  allocated ROB slot
out_src1_rdy, out_src2_rdy  out  1  value field holds operand
out_src1_val, out_src2_val  out  XLEN  operand value when rdy
out_src1_tag, out_src2_tag  out  TAG_BITS  producing slot when !rdy

Behaviour:
- Reset (async, _reset=0):
  - ARF all zero; all RAT valid bits 0; RAT tags 0.
  - out_valid=0; all out_* data fields 0.
- Handshake:
  - in_ready = rob_is_free && !flush && (!out_valid || out_ready).
  - Fire = in_valid && in_ready.
  - rob_do_alloc = fire (combinational); rob_alloc_arf/pc are pass-throughs.
- Latency: one cycle. On fire, out_* register the renamed packet; out_slot = rob_next_free.
- Output register:
  - Holds stable while out_valid && !out_ready.
  - Clears (out_valid<=0) when out_ready && !fire.
- Source resolution, per src, priority order:
  1. src==0 -> rdy=1, val=0.
  2. RAT[src] valid and commit_valid and commit_slot==RAT tag -> rdy=1, val=commit_result (same-cycle commit bypass).
  3. RAT[src] valid -> rdy=0, tag=RAT tag, val=0.
  4. Otherwise -> rdy=1, val=ARF[src].
- Sources use the RAT/ARF state before this instruction's own dst update (src==dst reads the older mapping).
- RAT write: on fire with in_dst!=0, RAT[in_dst] <= {valid=1, tag=rob_next_free}.
- Commit, when commit_valid:
  - If commit_arf!=0, ARF[commit_arf] <= commit_result.
  - If RAT[commit_arf] is valid with tag==commit_slot, clear its valid bit, unless the same cycle's rename writes that arf (rename wins).
  - Commits to r0 are discarded.
- Flush, synchronous, active for one or more cycles:
  - Clears all RAT valid bits and out_valid; no fire occurs.
  - A commit in the same cycle still writes the ARF; ARF contents are otherwise retained.
- ROB full: rob_is_free=0 -> in_ready=0, no alloc, RAT unchanged.
- Tag wrap-around (255->0) is handled by the ROB. This stage never compares tags by order, only by equality.
- Reset mid-operation returns to reset state immediately. In-flight packets are lost.

Decomposition:
- Shared package:
  - XLEN, NUM_ARF, ARF_BITS, TAG_BITS.
  - Typedef rat_entry_t {valid, tag}.
  - Typedef rename_pkt_t for the out_* bundle.
- One sub-module, arch_reg_file:
  - 2 combinational read ports, 1 synchronous write port, r0 reads zero.
  - Async reset of all entries to 0.
- The RAT and bypass logic stay in rename_stage.

Test Plan:
- Reset, then rename r3=... with src1=r1, src2=r2 (ARF holds r1=5, r2=7) and rob_next_free=0x10 -> next cycle out_valid=1, out_slot=0x10, both rdy=1, vals 5/7; RAT[r3]={1,0x10}.
- Rename dst r3 at slot 0x10, then an instruction with src1=r3 at slot 0x11 -> out_src1_rdy=0, out_src1_tag=0x10. Then commit slot 0x10 (r3, result 0x99) -> RAT[r3] cleared, ARF[r3]=0x99; next read of r3 gives rdy=1, val=0x99.
- Same cycle: commit slot 0x10 for r3 with result 0x42 while renaming src1=r3 -> out_src1_rdy=1, val=0x42.
- Same cycle: commit slot 0x10 for r3 while renaming dst r3 at slot 0x20 -> RAT[r3]={1,0x20}.
- Hold rob_is_free=0 with in_valid=1 -> in_ready=0, rob_do_alloc=0. Hold out_ready=0 with out_valid=1 -> out_* stable for 5 cycles.
- Rename r4@0x30, then assert flush -> out_valid=0, RAT all invalid. A following rename with src r4 gives rdy=1, val=ARF[r4]. Src r0 always gives rdy=1, val=0.

Source files
------------

// File: rtl/rename_stage_pkg.sv
// Shared types and sizes for the rename stage and its register file.
package rename_stage_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NUM_ARF  = 32;
  localparam int unsigned ARF_BITS = 5;
  localparam int unsigned TAG_BITS = 8;

  // One register alias table entry: valid means the latest value is still in flight.
  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
  } rat_entry_t;

  // A resolved source operand: either a value (rdy) or the producing ROB slot.
  typedef struct packed {
    logic                rdy;
    logic [XLEN-1:0]     val;
    logic [TAG_BITS-1:0] tag;
  } src_res_t;

  // Registered packet handed to issue.
  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [TAG_BITS-1:0] slot;
    src_res_t            src1;
    src_res_t            src2;
  } rename_pkt_t;

  // Resolve one source. Priority: r0, same-cycle commit bypass, in-flight tag, ARF value.
  function automatic src_res_t resolve_src(input logic [ARF_BITS-1:0] src,
                                           input rat_entry_t          ent,
                                           input logic [XLEN-1:0]     arf_val,
                                           input logic                cmt_valid,
                                           input logic [TAG_BITS-1:0] cmt_slot,
                                           input logic [XLEN-1:0]     cmt_result);
    src_res_t res;
    res = '0;
    if (src == '0) begin
      res.rdy = 1'b1;
    end else if (ent.valid && cmt_valid && (cmt_slot == ent.tag)) begin
      res.rdy = 1'b1;
      res.val = cmt_result;
    end else if (ent.valid) begin
      res.tag = ent.tag;
    end else begin
      res.rdy = 1'b1;
      res.val = arf_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/rename_stage_if.sv
// Decode, ROB allocation, commit, flush and issue signals of the rename stage.
interface rename_stage_if;
  import rename_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_pc;
  logic [ARF_BITS-1:0] in_src1;
  logic [ARF_BITS-1:0] in_src2;
  logic [ARF_BITS-1:0] in_dst;

  logic [TAG_BITS-1:0] rob_next_free;
  logic                rob_is_free;
  logic                rob_do_alloc;
  logic [ARF_BITS-1:0] rob_alloc_arf;
  logic [XLEN-1:0]     rob_alloc_pc;

  logic                commit_valid;
  logic [TAG_BITS-1:0] commit_slot;
  logic [ARF_BITS-1:0] commit_arf;
  logic [XLEN-1:0]     commit_result;

  logic                flush;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [TAG_BITS-1:0] out_slot;
  logic                out_src1_rdy;
  logic                out_src2_rdy;
  logic [XLEN-1:0]     out_src1_val;
  logic [XLEN-1:0]     out_src2_val;
  logic [TAG_BITS-1:0] out_src1_tag;
  logic [TAG_BITS-1:0] out_src2_tag;

  // Rename stage side.
  modport slave (
    input  in_valid, in_pc, in_src1, in_src2, in_dst,
    input  rob_next_free, rob_is_free,
    input  commit_valid, commit_slot, commit_arf, commit_result,
    input  flush, out_ready,
    output in_ready, rob_do_alloc, rob_alloc_arf, rob_alloc_pc,
    output out_valid, out_pc, out_slot,
    output out_src1_rdy, out_src2_rdy, out_src1_val, out_src2_val,
    output out_src1_tag, out_src2_tag
  );

  // Surrounding pipeline side.
  modport master (
    output in_valid, in_pc, in_src1, in_src2, in_dst,
    output rob_next_free, rob_is_free,
    output commit_valid, commit_slot, commit_arf, commit_result,
    output flush, out_ready,
    input  in_ready, rob_do_alloc, rob_alloc_arf, rob_alloc_pc,
    input  out_valid, out_pc, out_slot,
    input  out_src1_rdy, out_src2_rdy, out_src1_val, out_src2_val,
    input  out_src1_tag, out_src2_tag
  );

endinterface

// File: rtl/rename_stage_arch_reg_file.sv
// Architectural register file: two async read ports, one write port, r0 reads zero.
module arch_reg_file
  import rename_stage_pkg::*;
(
  input  logic                clock,
  input  logic                _reset,
  input  logic [ARF_BITS-1:0] raddr1,
  input  logic [ARF_BITS-1:0] raddr2,
  output logic [XLEN-1:0]     rdata1,
  output logic [XLEN-1:0]     rdata2,
  input  logic                we,
  input  logic [ARF_BITS-1:0] waddr,
  input  logic [XLEN-1:0]     wdata
);

  logic [XLEN-1:0] regs_q [NUM_ARF];
  logic [XLEN-1:0] regs_d [NUM_ARF];

  // Next-state: single write, writes to r0 dropped.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage with async clear.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/rename_stage.sv
// In-order rename stage: allocates ROB slots, resolves sources via the RAT/ARF,
// tracks commits and flushes, and registers one packet per cycle toward issue.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic          clock,
  input  logic          _reset,
  rename_stage_if.slave bus
);

  rat_entry_t [NUM_ARF-1:0] rat_q, rat_d;
  rename_pkt_t              pkt_q, pkt_d;

  logic            fire;
  logic [XLEN-1:0] arf_rdata1, arf_rdata2;
  src_res_t        src1_res, src2_res;

  arch_reg_file u_arf (
    .clock  (clock),
    ._reset (_reset),
    .raddr1 (bus.in_src1),
    .raddr2 (bus.in_src2),
    .rdata1 (arf_rdata1),
    .rdata2 (arf_rdata2),
    .we     (bus.commit_valid),
    .waddr  (bus.commit_arf),
    .wdata  (bus.commit_result)
  );

  // Handshake: accept only when the ROB has room, no flush, and the output can move.
  always_comb begin
    bus.in_ready      = bus.rob_is_free && !bus.flush && (!pkt_q.valid || bus.out_ready);
    fire              = bus.in_valid && bus.in_ready;
    bus.rob_do_alloc  = fire;
    bus.rob_alloc_arf = bus.in_dst;
    bus.rob_alloc_pc  = bus.in_pc;
  end

  // Sources see the RAT/ARF before this instruction's own destination update.
  always_comb begin
    src1_res = resolve_src(bus.in_src1, rat_q[bus.in_src1], arf_rdata1,
                           bus.commit_valid, bus.commit_slot, bus.commit_result);
    src2_res = resolve_src(bus.in_src2, rat_q[bus.in_src2], arf_rdata2,
                           bus.commit_valid, bus.commit_slot, bus.commit_result);
  end

  // RAT next-state: commit clears a matching mapping, rename overrides, flush drops all.
  always_comb begin
    rat_d = rat_q;
    if (bus.commit_valid && rat_q[bus.commit_arf].valid &&
        (rat_q[bus.commit_arf].tag == bus.commit_slot)) begin
      rat_d[bus.commit_arf].valid = 1'b0;
    end
    if (fire && (bus.in_dst != '0)) begin
      rat_d[bus.in_dst].valid = 1'b1;
      rat_d[bus.in_dst].tag   = bus.rob_next_free;
    end
    if (bus.flush) begin
      for (int i = 0; i < NUM_ARF; i++) begin
        rat_d[i].valid = 1'b0;
      end
    end
  end

  // Output packet next-state: load on fire, drop valid when drained or flushed.
  always_comb begin
    pkt_d = pkt_q;
    if (fire) begin
      pkt_d.valid = 1'b1;
      pkt_d.pc    = bus.in_pc;
      pkt_d.slot  = bus.rob_next_free;
      pkt_d.src1  = src1_res;
      pkt_d.src2  = src2_res;
    end else if (bus.out_ready || bus.flush) begin
      pkt_d.valid = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      rat_q <= '0;
      pkt_q <= '0;
    end else begin
      rat_q <= rat_d;
      pkt_q <= pkt_d;
    end
  end

  // Issue-side outputs.
  always_comb begin
    bus.out_valid    = pkt_q.valid;
    bus.out_pc       = pkt_q.pc;
    bus.out_slot     = pkt_q.slot;
    bus.out_src1_rdy = pkt_q.src1.rdy;
    bus.out_src1_val = pkt_q.src1.val;
    bus.out_src1_tag = pkt_q.src1.tag;
    bus.out_src2_rdy = pkt_q.src2.rdy;
    bus.out_src2_val = pkt_q.src2.val;
    bus.out_src2_tag = pkt_q.src2.tag;
  end

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: directed scenarios plus random traffic
// against a behavioural model of the RAT, ARF and output register.
module tb_rename_stage;
  import rename_stage_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  rename_stage_if bus ();

  rename_stage u_dut (
    .clock  (clock),
    ._reset (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  logic [63:0] m_arf [32];
  bit          m_rv  [32];
  logic [7:0]  m_rt  [32];
  bit          m_ov;
  logic [63:0] m_pc;
  logic [7:0]  m_slot;
  bit          m_r1, m_r2;
  logic [63:0] m_v1, m_v2;
  logic [7:0]  m_t1, m_t2;
  bit          last_fire;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_arf[i] = '0;
      m_rv[i]  = 1'b0;
      m_rt[i]  = '0;
    end
    m_ov = 1'b0;
  endtask

  task automatic ref_src(input logic [4:0] s, output bit rdy, output logic [63:0] v,
                         output logic [7:0] t);
    rdy = 1'b1;
    v   = '0;
    t   = '0;
    if (s == 0) begin
      rdy = 1'b1;
    end else if (m_rv[s] && bus.commit_valid && bus.commit_slot == m_rt[s]) begin
      v = bus.commit_result;
    end else if (m_rv[s]) begin
      rdy = 1'b0;
      t   = m_rt[s];
    end else begin
      v = m_arf[s];
    end
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.in_pc         = '0;
    bus.in_src1       = '0;
    bus.in_src2       = '0;
    bus.in_dst        = '0;
    bus.rob_next_free = '0;
    bus.rob_is_free   = 1'b1;
    bus.commit_valid  = 1'b0;
    bus.commit_slot   = '0;
    bus.commit_arf    = '0;
    bus.commit_result = '0;
    bus.flush         = 1'b0;
    bus.out_ready     = 1'b1;
  endtask

  task automatic rename(input logic [63:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [7:0] slot);
    bus.in_valid      = 1'b1;
    bus.in_pc         = pc;
    bus.in_src1       = s1;
    bus.in_src2       = s2;
    bus.in_dst        = d;
    bus.rob_next_free = slot;
  endtask

  task automatic commit(input logic [7:0] slot, input logic [4:0] arf, input logic [63:0] res);
    bus.commit_valid  = 1'b1;
    bus.commit_slot   = slot;
    bus.commit_arf    = arf;
    bus.commit_result = res;
  endtask

  task automatic check_out();
    check("out_valid", bus.out_valid, m_ov);
    if (m_ov) begin
      check("out_pc", bus.out_pc, m_pc);
      check("out_slot", bus.out_slot, m_slot);
      check("src1_rdy", bus.out_src1_rdy, m_r1);
      check("src1_val", bus.out_src1_val, m_v1);
      if (!m_r1) check("src1_tag", bus.out_src1_tag, m_t1);
      check("src2_rdy", bus.out_src2_rdy, m_r2);
      check("src2_val", bus.out_src2_val, m_v2);
      if (!m_r2) check("src2_tag", bus.out_src2_tag, m_t2);
    end
  endtask

  // One clock: check combinational handshake, advance the model, check registered outputs.
  task automatic tick();
    bit          exp_ready, fire, r1, r2;
    logic [63:0] v1, v2;
    logic [7:0]  t1, t2;
    logic [4:0]  ca;
    #1;
    exp_ready = bus.rob_is_free && !bus.flush && (!m_ov || bus.out_ready);
    fire      = bus.in_valid && exp_ready;
    check("in_ready", bus.in_ready, exp_ready);
    check("do_alloc", bus.rob_do_alloc, fire);
    check("alloc_arf", bus.rob_alloc_arf, bus.in_dst);
    check("alloc_pc", bus.rob_alloc_pc, bus.in_pc);
    ref_src(bus.in_src1, r1, v1, t1);
    ref_src(bus.in_src2, r2, v2, t2);
    if (fire) begin
      m_ov = 1'b1; m_pc = bus.in_pc; m_slot = bus.rob_next_free;
      m_r1 = r1; m_v1 = v1; m_t1 = t1;
      m_r2 = r2; m_v2 = v2; m_t2 = t2;
    end else if (bus.out_ready || bus.flush) begin
      m_ov = 1'b0;
    end
    if (bus.commit_valid) begin
      ca = bus.commit_arf;
      if (ca != 0) m_arf[ca] = bus.commit_result;
      if (m_rv[ca] && m_rt[ca] == bus.commit_slot) m_rv[ca] = 1'b0;
    end
    if (fire && bus.in_dst != 0) begin
      m_rv[bus.in_dst] = 1'b1;
      m_rt[bus.in_dst] = bus.rob_next_free;
    end
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) m_rv[i] = 1'b0;
    end
    last_fire = fire;
    @(posedge clock);
    #1;
    check_out();
  endtask

  typedef struct {
    logic [7:0] slot;
    logic [4:0] arf;
  } inflight_t;
  inflight_t   q[$];
  logic [7:0]  nf;
  inflight_t   e;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    #23;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_pc", bus.out_pc, 64'h0);
    check("rst_out_slot", bus.out_slot, 8'h0);
    check("rst_src1_val", bus.out_src1_val, 64'h0);
    check("rst_src2_tag", bus.out_src2_tag, 8'h0);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    // Seed r1=5, r2=7 through the commit path.
    commit(8'h01, 5'd1, 64'd5); tick();
    commit(8'h02, 5'd2, 64'd7); tick();
    idle();

    rename(64'h1000, 5'd1, 5'd2, 5'd3, 8'h10); tick();
    check("tp1_valid", bus.out_valid, 1'b1);
    check("tp1_slot", bus.out_slot, 8'h10);
    check("tp1_src1", {bus.out_src1_rdy, bus.out_src1_val}, {1'b1, 64'd5});
    check("tp1_src2", {bus.out_src2_rdy, bus.out_src2_val}, {1'b1, 64'd7});

    rename(64'h1004, 5'd3, 5'd0, 5'd5, 8'h11); tick();
    check("tp2_src1_rdy", bus.out_src1_rdy, 1'b0);
    check("tp2_src1_tag", bus.out_src1_tag, 8'h10);
    check("tp2_src2_r0", {bus.out_src2_rdy, bus.out_src2_val}, {1'b1, 64'd0});

    idle(); commit(8'h10, 5'd3, 64'h99); tick();
    idle(); rename(64'h1008, 5'd3, 5'd3, 5'd0, 8'h12); tick();
    check("tp2_after_commit", {bus.out_src1_rdy, bus.out_src1_val}, {1'b1, 64'h99});

    // Same-cycle commit bypass.
    idle(); rename(64'h100c, 5'd0, 5'd0, 5'd3, 8'h13); tick();
    rename(64'h1010, 5'd3, 5'd1, 5'd6, 8'h14); commit(8'h13, 5'd3, 64'h42); tick();
    check("tp3_bypass", {bus.out_src1_rdy, bus.out_src1_val}, {1'b1, 64'h42});

    // Rename wins over a commit clearing the same arf.
    idle(); rename(64'h1014, 5'd0, 5'd0, 5'd3, 8'h15); tick();
    rename(64'h1018, 5'd0, 5'd0, 5'd3, 8'h20); commit(8'h15, 5'd3, 64'h77); tick();
    idle(); rename(64'h101c, 5'd3, 5'd0, 5'd0, 8'h21); tick();
    check("tp4_rename_wins", {bus.out_src1_rdy, bus.out_src1_tag}, {1'b0, 8'h20});

    // ROB full.
    idle(); rename(64'h1020, 5'd1, 5'd2, 5'd7, 8'h22); bus.rob_is_free = 1'b0; #1;
    check("tp5_full_ready", bus.in_ready, 1'b0);
    check("tp5_full_alloc", bus.rob_do_alloc, 1'b0);
    tick();

    // Backpressure hold.
    bus.rob_is_free = 1'b1; tick();
    rename(64'h2000, 5'd4, 5'd5, 5'd8, 8'h23); bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("tp5_hold_slot", bus.out_slot, 8'h22);
      check("tp5_hold_pc", bus.out_pc, 64'h1020);
    end

    // Flush.
    idle(); rename(64'h3000, 5'd0, 5'd0, 5'd4, 8'h30); tick();
    bus.flush = 1'b1; rename(64'h3004, 5'd4, 5'd0, 5'd9, 8'h31); tick();
    check("tp6_flush_valid", bus.out_valid, 1'b0);
    bus.flush = 1'b0; tick();
    check("tp6_after_flush", {bus.out_src1_rdy, bus.out_src1_val}, {1'b1, 64'h0});

    // Random traffic.
    idle();
    nf = 8'h40;
    q.delete();
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.in_pc         = {$urandom, $urandom};
      bus.in_src1       = 5'($urandom_range(0, 7));
      bus.in_src2       = 5'($urandom_range(0, 7));
      bus.in_dst        = 5'($urandom_range(0, 7));
      bus.rob_next_free = nf;
      bus.rob_is_free   = ($urandom_range(0, 9) != 0);
      bus.out_ready     = ($urandom_range(0, 9) < 7);
      bus.flush         = ($urandom_range(0, 49) == 0);
      bus.commit_valid  = 1'b0;
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        e = q.pop_front();
        commit(e.slot, e.arf, {$urandom, $urandom});
      end else if ($urandom_range(0, 9) == 0) begin
        commit(8'($urandom), 5'($urandom_range(0, 31)), {$urandom, $urandom});
      end
      tick();
      if (bus.flush) q.delete();
      else if (last_fire) q.push_back('{slot: bus.rob_next_free, arf: bus.in_dst});
      if (last_fire) nf++;
    end

    // Reset in the middle of traffic.
    rename(64'h5000, 5'd1, 5'd2, 5'd3, nf); bus.out_ready = 1'b0; bus.rob_is_free = 1'b1;
    bus.flush = 1'b0; bus.commit_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_slot", bus.out_slot, 8'h0);
    @(negedge clock);
    rst_n = 1'b1;
    idle();
    @(posedge clock);
    #1;
    rename(64'h6000, 5'd1, 5'd3, 5'd1, 8'h50); tick();
    check("midrst_arf", {bus.out_src1_rdy, bus.out_src1_val}, {1'b1, 64'h0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
